// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the RV32 subset datapath: steps FETCH..WB with memory waits and traps.
// Optional perf counters are built when PERF_COUNTERS_EN is defined.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             regwrite,
  output logic             alusrc,
  output logic [1:0]       aluop,
  output logic             memread,
  output logic             memwrite,
  output logic             memtoreg,
  output logic             retire,
  output logic             trap,
  output logic             trap_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  // The counter only needs to hold MEM_TIMEOUT-1; the final wait cycle triggers TRAP.
  localparam int              WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam bit              TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t            r_state;
  state_t            w_next;
  logic              r_cause;
  logic              w_next_cause;
  logic [WAIT_W-1:0] r_wait_cnt;

  logic w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_beq;
  logic w_waiting, w_timeout;

  assign w_is_r    = (opcode == OP_R);
  assign w_is_i    = (opcode == OP_I);
  assign w_is_lw   = (opcode == OP_LW);
  assign w_is_sw   = (opcode == OP_SW);
  assign w_is_beq  = (opcode == OP_BEQ);
  assign w_waiting = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;
  assign w_timeout = TIMEOUT_EN && w_waiting && (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cause    <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_next_cause;
      if (w_waiting && !w_timeout && TIMEOUT_EN)
        r_wait_cnt <= r_wait_cnt + 1'b1;
      else
        r_wait_cnt <= '0;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_next_cause = r_cause;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    ir_write     = 1'b0;
    regwrite     = 1'b0;
    alusrc       = 1'b0;
    aluop        = 2'd0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    memtoreg     = 1'b0;
    retire       = 1'b0;
    trap         = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        memread = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = S_DECODE;
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_next_cause = 1'b1;
        end
      end
      S_DECODE: begin
        if (w_is_r || w_is_i || w_is_lw || w_is_sw || w_is_beq) begin
          w_next = S_EXEC;
        end else begin
          w_next       = S_TRAP;
          w_next_cause = 1'b0;
        end
      end
      S_EXEC: begin
        alusrc = w_is_i || w_is_lw || w_is_sw;
        if (w_is_beq) begin
          aluop    = 2'd1;
          pc_write = zero;
          pc_src   = 1'b1;
          retire   = 1'b1;
          w_next   = S_FETCH;
        end else if (w_is_lw || w_is_sw) begin
          aluop  = 2'd0;
          w_next = S_MEM;
        end else if (w_is_r || w_is_i) begin
          aluop  = 2'd2;
          w_next = S_WB;
        end else begin
          // Opcode changed after DECODE; treat as illegal rather than guess.
          w_next       = S_TRAP;
          w_next_cause = 1'b0;
        end
      end
      S_MEM: begin
        alusrc   = 1'b1;
        memread  = w_is_lw;
        memwrite = !w_is_lw;
        if (mem_ready) begin
          if (w_is_lw) begin
            w_next = S_WB;
          end else begin
            retire = 1'b1;
            w_next = S_FETCH;
          end
        end else if (w_timeout) begin
          w_next       = S_TRAP;
          w_next_cause = 1'b1;
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        memtoreg = w_is_lw;
        retire   = 1'b1;
        w_next   = S_FETCH;
      end
      S_TRAP: trap = 1'b1;
      default: w_next = S_IDLE;
    endcase
  end

  assign state      = r_state;
  assign trap_cause = r_cause;

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_instret;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cycle_cnt <= '0;
      r_instret   <= '0;
    end else begin
      if ((r_state != S_IDLE) && (r_state != S_TRAP))
        r_cycle_cnt <= r_cycle_cnt + 1'b1;
      if (retire)
        r_instret <= r_instret + 1'b1;
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instret   = r_instret;
`else
  assign cycle_cnt = '0;
  assign instret   = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized bench for multicycle_ctrl: expected state sequences are built per instruction
// from phase lengths and memory wait counts, then replayed cycle by cycle.
module tb_multicycle_ctrl;

  localparam int T = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                         S_MEM = 3'd4, S_WB = 3'd5, S_TRAP = 3'd7;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011,
                         OP_SW = 7'b0100011, OP_BEQ = 7'b1100011;

  logic        clk, rst;
  logic [6:0]  opcode;
  logic        zero, mem_ready;
  logic        pc_write, pc_src, ir_write, regwrite, alusrc;
  logic [1:0]  aluop;
  logic        memread, memwrite, memtoreg, retire, trap, trap_cause;
  logic [2:0]  state;
  logic [31:0] cycle_cnt, instret;

  int          n_checks;
  int          n_errors;
  logic [2:0]  exp_q[$];
  logic [31:0] exp_cyc;
  logic [31:0] exp_ret;

  multicycle_ctrl #(.MEM_TIMEOUT(T), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .regwrite(regwrite),
    .alusrc(alusrc), .aluop(aluop), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .retire(retire), .trap(trap), .trap_cause(trap_cause),
    .state(state), .cycle_cnt(cycle_cnt), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [11:0] outs_now();
    return {pc_write, pc_src, ir_write, regwrite, alusrc, aluop, memread, memwrite,
            memtoreg, retire, trap};
  endfunction

  task automatic check_perf();
`ifdef PERF_COUNTERS_EN
    check("cycle_cnt", cycle_cnt, exp_cyc);
    check("instret", instret, exp_ret);
`else
    check("cycle_cnt_tied", cycle_cnt, 32'd0);
    check("instret_tied", instret, 32'd0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; mem_ready = 1'b0; zero = 1'b0; opcode = 7'd0;
    #1;
    exp_cyc = 0; exp_ret = 0;
    check("rst_state", 32'(state), 32'(S_IDLE));
    check("rst_outs", 32'(outs_now()), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    check_perf();
    rst = 1'b1;
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw, input logic z);
    bit is_r, is_i, is_lw, is_sw, is_beq, legal, trapped, cause;
    int fcyc, mcyc, n, fi, mi, pw, iw;
    logic [2:0] es;
    is_r = (op == OP_R); is_i = (op == OP_I); is_lw = (op == OP_LW);
    is_sw = (op == OP_SW); is_beq = (op == OP_BEQ);
    legal = is_r || is_i || is_lw || is_sw || is_beq;
    trapped = 0; cause = 0; mcyc = 0;
    exp_q.delete();
    fcyc = (fw >= T) ? T : fw + 1;
    repeat (fcyc) exp_q.push_back(S_FETCH);
    if (fw >= T) begin
      trapped = 1; cause = 1;
    end else begin
      exp_q.push_back(S_DECODE);
      if (!legal) begin
        trapped = 1; cause = 0;
      end else begin
        exp_q.push_back(S_EXEC);
        if (is_lw || is_sw) begin
          mcyc = (mw >= T) ? T : mw + 1;
          repeat (mcyc) exp_q.push_back(S_MEM);
          if (mw >= T) begin trapped = 1; cause = 1; end
        end
        if (!trapped && !is_sw && !is_beq) exp_q.push_back(S_WB);
      end
    end
    n = exp_q.size(); fi = 0; mi = 0; pw = 0; iw = 0;
    for (int k = 0; k < n; k++) begin
      es = exp_q.pop_front();
      @(negedge clk);
      opcode = op;
      if (es == S_FETCH) begin
        mem_ready = (fi == fw); fi++;
      end else if (es == S_MEM) begin
        mem_ready = (mi == mw); mi++;
      end else begin
        mem_ready = 1'($urandom_range(0, 1));
      end
      zero = (es == S_EXEC) ? z : 1'($urandom_range(0, 1));
      #1;
      check("state", 32'(state), 32'(es));
      check_perf();
      check("memread", 32'(memread), 32'((es == S_FETCH) || (es == S_MEM && is_lw)));
      check("memwrite", 32'(memwrite), 32'(es == S_MEM && is_sw));
      check("regwrite", 32'(regwrite), 32'(es == S_WB));
      check("retire", 32'(retire), 32'((k == n - 1) && !trapped));
      check("trap_low", 32'(trap), 32'd0);
      if (es == S_EXEC) begin
        check("aluop", 32'(aluop), is_beq ? 32'd1 : ((is_lw || is_sw) ? 32'd0 : 32'd2));
        check("alusrc", 32'(alusrc), 32'(is_i || is_lw || is_sw));
        if (is_beq) begin
          check("beq_pc_src", 32'(pc_src), 32'd1);
          check("beq_pc_write", 32'(pc_write), 32'(z));
        end
      end
      if (es == S_WB) check("memtoreg", 32'(memtoreg), 32'(is_lw));
      pw += int'(pc_write);
      iw += int'(ir_write);
      exp_cyc++;
    end
    if (!trapped) exp_ret++;
    check("pc_write_total", 32'(pw), (fw < T) ? 32'(1 + int'(is_beq && z)) : 32'd0);
    check("ir_write_total", 32'(iw), 32'(fw < T));
    if (trapped) begin
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        mem_ready = 1'(k & 1); zero = 1'($urandom_range(0, 1)); opcode = 7'($urandom);
        #1;
        check("trap_state", 32'(state), 32'(S_TRAP));
        check("trap_flag", 32'(trap), 32'd1);
        check("trap_cause", 32'(trap_cause), 32'(cause));
        check("trap_strobes", 32'(outs_now()), 32'd1);
        check_perf();
      end
      do_reset();
    end
  endtask

  task automatic reset_in_mem();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      opcode = OP_SW; mem_ready = (k == 0); zero = 1'b0;
      #1;
      check("mid_state", 32'(state), 32'(k + 1));
    end
    check("mid_memwrite_on", 32'(memwrite), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_memwrite_off", 32'(memwrite), 32'd0);
    check("mid_state_idle", 32'(state), 32'(S_IDLE));
    do_reset();
  endtask

  initial begin
    logic [6:0] op;
    int fw, mw;
    n_checks = 0; n_errors = 0;
    rst = 1'b0; opcode = 7'd0; zero = 1'b0; mem_ready = 1'b0;
    exp_cyc = 0; exp_ret = 0;
    do_reset();
    run_instr(OP_R, 0, 0, 1'b0);
    run_instr(OP_LW, 0, 3, 1'b0);
    run_instr(OP_BEQ, 0, 0, 1'b1);
    run_instr(OP_BEQ, 0, 0, 1'b0);
    run_instr(OP_SW, 1, 2, 1'b0);
    run_instr(OP_I, 2, 0, 1'b0);
    run_instr(7'h7f, 0, 0, 1'b0);
    run_instr(OP_R, T, 0, 1'b0);
    run_instr(OP_LW, 0, T + 1, 1'b0);
    run_instr(OP_SW, 0, T, 1'b0);
    do_reset();
    repeat (3) run_instr(OP_R, 0, 0, 1'b0);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
`ifdef PERF_COUNTERS_EN
    check("perf_instret_3r", instret, 32'd3);
    check("perf_cycles_3r", cycle_cnt, 32'd12);
`else
    check("perf_instret_3r", instret, 32'd0);
    check("perf_cycles_3r", cycle_cnt, 32'd0);
`endif
    do_reset();
    reset_in_mem();
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: op = OP_R;
        1: op = OP_I;
        2: op = OP_LW;
        3: op = OP_SW;
        4: op = OP_BEQ;
        default: op = 7'($urandom);
      endcase
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 2);
      run_instr(op, fw, mw, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
